// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared types for the LED counter run-control slice.
//   state_e : run-control FSM state encoding (also driven out on the state port)
//   CNT_W   : width of the counter value fed back from the datapath
package counter_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      HALT  = 2'd3
   } state_e;

   // Value at which a non-wrapping count must stop: all ones counting up,
   // all zeros counting down.
   function automatic logic [CNT_W-1:0] terminal_val(input logic up);
      return up ? {CNT_W{1'b1}} : {CNT_W{1'b0}};
   endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// counter_ctrl_if
//   Bundles the button inputs, counter feedback and counter control strobes
//   of the run-control sequencer.
//   master : the sequencer (reads buttons and cnt_val, drives strobes/state)
//   slave  : the surroundings (drive buttons and cnt_val, read strobes/state)
interface counter_ctrl_if;
   import counter_pkg::*;

   logic             btn_start;
   logic             btn_stop;
   logic             btn_dir;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_en;
   logic             cnt_up;
   logic             cnt_clr;
   state_e           state;

   modport master (
      input  btn_start, btn_stop, btn_dir, cnt_val,
      output cnt_en, cnt_up, cnt_clr, state
   );

   modport slave (
      output btn_start, btn_stop, btn_dir, cnt_val,
      input  cnt_en, cnt_up, cnt_clr, state
   );

endinterface

// File: rtl/btn_debounce.sv
// btn_debounce
//   Accepts a new button level once the (already synchronized) raw input has
//   disagreed with the accepted level for DEBOUNCE_CYC consecutive cycles, and
//   emits a one-cycle pulse on each accepted rising edge.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   din   : raw button level
//   level : accepted (debounced) level
//   rise  : one-cycle pulse when level goes 0 -> 1
module btn_debounce #(
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise
);

   localparam int            CW       = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

   logic          din_reg;
   logic [CW-1:0] cnt_reg;
   logic          level_reg;
   logic          rise_reg;

   // din is registered once before the comparison, so an input that rises in
   // cycle t produces rise in cycle t + DEBOUNCE_CYC + 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         din_reg   <= 1'b0;
         cnt_reg   <= '0;
         level_reg <= 1'b0;
         rise_reg  <= 1'b0;
      end else begin
         din_reg  <= din;
         rise_reg <= 1'b0;
         if (din_reg != level_reg) begin
            if (cnt_reg == CNT_LAST) begin
               level_reg <= din_reg;
               cnt_reg   <= '0;
               rise_reg  <= din_reg;
            end else begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end else begin
            // Any glitch back to the accepted level restarts the count.
            cnt_reg <= '0;
         end
      end
   end

   assign level = level_reg;
   assign rise  = rise_reg;

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl
//   Run-control sequencer for the 4-bit LED counter: debounces start/stop/dir
//   buttons and drives count enable, direction and clear from a prescaled tick.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : counter_ctrl_if.master
//         in  btn_start, btn_stop, btn_dir (synchronized levels), cnt_val
//         out cnt_en (count strobe), cnt_up (1 = up), cnt_clr (clear strobe),
//             state (state_e)
module counter_ctrl
   import counter_pkg::*;
#(
   parameter int TICK_DIV     = 50_000_000,
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int WRAP         = 1
) (
   input  logic            clk,
   input  logic            rst,
   counter_ctrl_if.master  bus
);

   localparam int            PW         = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   // Button index order: 0 = start, 1 = stop, 2 = dir.
   logic [2:0] btn_raw;
   logic [2:0] btn_rise;
   logic [2:0] btn_level_unused;

   assign btn_raw = {bus.btn_dir, bus.btn_stop, bus.btn_start};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_debounce
         btn_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
         ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .din   (btn_raw[gi]),
            .level (btn_level_unused[gi]),
            .rise  (btn_rise[gi])
         );
      end
   endgenerate

   logic start_ev;
   logic stop_ev;
   logic dir_ev;

   assign start_ev = btn_rise[0];
   assign stop_ev  = btn_rise[1];
   assign dir_ev   = btn_rise[2];

   state_e        state_reg;
   logic [PW-1:0] presc_reg;
   logic          cnt_en_reg;
   logic          cnt_up_reg;
   logic          cnt_clr_reg;

   logic tick;
   logic at_terminal;

   assign tick        = (state_reg == RUN) && (presc_reg == PRESC_LAST);
   assign at_terminal = (bus.cnt_val == terminal_val(cnt_up_reg));

   // The prescaler is held at 0 in every state but RUN, so each entry into
   // RUN starts a full TICK_DIV period. Strobes default low every cycle and
   // cnt_clr is only raised on transitions where cnt_en cannot be.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         presc_reg   <= '0;
         cnt_en_reg  <= 1'b0;
         cnt_up_reg  <= 1'b1;
         cnt_clr_reg <= 1'b0;
      end else begin
         cnt_en_reg  <= 1'b0;
         cnt_clr_reg <= 1'b0;

         if (dir_ev && (state_reg != RUN)) begin
            cnt_up_reg <= ~cnt_up_reg;
         end

         case (state_reg)
            IDLE: begin
               presc_reg <= '0;
               if (start_ev && !stop_ev) begin
                  state_reg   <= RUN;
                  cnt_clr_reg <= 1'b1;
               end
            end

            RUN: begin
               if (stop_ev) begin
                  // Leaving RUN on a tick cycle drops that tick's strobe.
                  state_reg <= PAUSE;
                  presc_reg <= '0;
               end else if (tick) begin
                  presc_reg <= '0;
                  if ((WRAP == 0) && at_terminal) begin
                     state_reg <= HALT;
                  end else begin
                     cnt_en_reg <= 1'b1;
                  end
               end else begin
                  presc_reg <= presc_reg + 1'b1;
               end
            end

            PAUSE: begin
               presc_reg <= '0;
               if (stop_ev) begin
                  state_reg   <= IDLE;
                  cnt_clr_reg <= 1'b1;
               end else if (start_ev) begin
                  state_reg <= RUN;
               end
            end

            HALT: begin
               presc_reg <= '0;
               if (stop_ev) begin
                  state_reg   <= IDLE;
                  cnt_clr_reg <= 1'b1;
               end else if (start_ev) begin
                  state_reg   <= RUN;
                  cnt_clr_reg <= 1'b1;
               end
            end

            default: begin
               state_reg <= IDLE;
               presc_reg <= '0;
            end
         endcase
      end
   end

   assign bus.cnt_en  = cnt_en_reg;
   assign bus.cnt_up  = cnt_up_reg;
   assign bus.cnt_clr = cnt_clr_reg;
   assign bus.state   = state_reg;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl
//   Directed bench for counter_ctrl with TICK_DIV=4, DEBOUNCE_CYC=3.
//   dut_w runs with WRAP=1 and is fed back from a small counter model;
//   dut_h runs with WRAP=0 and has its cnt_val driven directly.
module tb_counter_ctrl;
   import counter_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_start;
   logic       btn_stop;
   logic       btn_dir;
   logic [3:0] cnt_model;
   logic [3:0] cnt_val_h;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   counter_ctrl_if bus_w ();
   counter_ctrl_if bus_h ();

   assign bus_w.btn_start = btn_start;
   assign bus_w.btn_stop  = btn_stop;
   assign bus_w.btn_dir   = btn_dir;
   assign bus_w.cnt_val   = cnt_model;
   assign bus_h.btn_start = btn_start;
   assign bus_h.btn_stop  = btn_stop;
   assign bus_h.btn_dir   = btn_dir;
   assign bus_h.cnt_val   = cnt_val_h;

   counter_ctrl #(.TICK_DIV(4), .DEBOUNCE_CYC(3), .WRAP(1)) dut_w (
      .clk (clk),
      .rst (rst),
      .bus (bus_w)
   );

   counter_ctrl #(.TICK_DIV(4), .DEBOUNCE_CYC(3), .WRAP(0)) dut_h (
      .clk (clk),
      .rst (rst),
      .bus (bus_h)
   );

   // External 4-bit counter: updates the cycle after a strobe.
   always @(posedge clk) begin
      if (rst)                cnt_model <= 4'd0;
      else if (bus_w.cnt_clr) cnt_model <= 4'd0;
      else if (bus_w.cnt_en)  cnt_model <= bus_w.cnt_up ? cnt_model + 4'd1 : cnt_model - 4'd1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic s, input logic p, input logic d, input int n);
      btn_start = s;
      btn_stop  = p;
      btn_dir   = d;
      repeat (n) step();
   endtask

   task automatic release_all();
      btn_start = 1'b0;
      btn_stop  = 1'b0;
      btn_dir   = 1'b0;
      repeat (6) step();
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      btn_start = 1'b0;
      btn_stop  = 1'b0;
      btn_dir   = 1'b0;
      cnt_val_h = 4'd0;
      repeat (2) step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      btn_start = 1'b0;
      btn_stop  = 1'b0;
      btn_dir   = 1'b0;
      cnt_val_h = 4'd0;
      repeat (2) step();
      checks++; if (bus_w.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus_w.state); end
      checks++; if (bus_w.cnt_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", bus_w.cnt_en); end
      checks++; if (bus_w.cnt_clr !== 1'b0) begin errors++; $display("FAIL reset_clr: got %b expected 0", bus_w.cnt_clr); end
      checks++; if (bus_w.cnt_up !== 1'b1) begin errors++; $display("FAIL reset_up: got %b expected 1", bus_w.cnt_up); end
      checks++; if (bus_h.state !== IDLE) begin errors++; $display("FAIL reset_state_h: got %0d expected 0", bus_h.state); end
      rst = 1'b0;
      step();
      $display("test_reset done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_short_press();
      btn_start = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         step();
         if (c == 2) btn_start = 1'b0;
         checks++; if (bus_w.state !== IDLE) begin errors++; $display("FAIL short_state c=%0d: got %0d expected 0", c, bus_w.state); end
         checks++; if (bus_w.cnt_en !== 1'b0 || bus_w.cnt_clr !== 1'b0) begin errors++; $display("FAIL short_strobe c=%0d: got en=%b clr=%b expected 0/0", c, bus_w.cnt_en, bus_w.cnt_clr); end
      end
      $display("test_short_press done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_start();
      logic   exp_en;
      logic   exp_clr;
      state_e exp_state;
      btn_start = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         step();
         if (c == 5) btn_start = 1'b0;
         exp_clr   = (c == 5);
         exp_en    = (c >= 9) && (((c - 9) % 4) == 0);
         exp_state = (c >= 5) ? RUN : IDLE;
         checks++; if (bus_w.cnt_clr !== exp_clr) begin errors++; $display("FAIL start_clr c=%0d: got %b expected %b", c, bus_w.cnt_clr, exp_clr); end
         checks++; if (bus_w.cnt_en !== exp_en) begin errors++; $display("FAIL start_en c=%0d: got %b expected %b", c, bus_w.cnt_en, exp_en); end
         checks++; if (bus_w.state !== exp_state) begin errors++; $display("FAIL start_state c=%0d: got %0d expected %0d", c, bus_w.state, exp_state); end
      end
      $display("test_start done: checks=%0d errors=%0d", checks, errors);
   endtask

   // Starts in RUN (left there by test_start).
   task automatic test_start_stop_together();
      btn_start = 1'b1;
      btn_stop  = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         step();
         if (c == 5) begin
            btn_start = 1'b0;
            btn_stop  = 1'b0;
         end
         checks++; if (bus_w.cnt_clr !== 1'b0) begin errors++; $display("FAIL both_clr c=%0d: got %b expected 0", c, bus_w.cnt_clr); end
         if (c >= 5) begin
            checks++; if (bus_w.state !== PAUSE) begin errors++; $display("FAIL both_state c=%0d: got %0d expected 2", c, bus_w.state); end
            checks++; if (bus_w.cnt_en !== 1'b0) begin errors++; $display("FAIL both_en c=%0d: got %b expected 0", c, bus_w.cnt_en); end
         end
      end
      $display("test_start_stop_together done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_dir();
      logic [3:0] prev;
      logic [3:0] exp_val;
      do_reset();
      hold(1'b1, 1'b0, 1'b0, 5);
      release_all();
      hold(1'b0, 1'b0, 1'b1, 5);
      release_all();
      checks++; if (bus_w.state !== RUN) begin errors++; $display("FAIL dir_run_state: got %0d expected 1", bus_w.state); end
      checks++; if (bus_w.cnt_up !== 1'b1) begin errors++; $display("FAIL dir_run_ignored: got %b expected 1", bus_w.cnt_up); end
      hold(1'b0, 1'b1, 1'b0, 5);
      checks++; if (bus_w.state !== PAUSE) begin errors++; $display("FAIL dir_pause_state: got %0d expected 2", bus_w.state); end
      release_all();
      prev = cnt_model;
      hold(1'b0, 1'b0, 1'b1, 5);
      checks++; if (bus_w.cnt_up !== 1'b0) begin errors++; $display("FAIL dir_pause_toggle: got %b expected 0", bus_w.cnt_up); end
      release_all();
      checks++; if (bus_w.cnt_up !== 1'b0) begin errors++; $display("FAIL dir_pause_hold: got %b expected 0", bus_w.cnt_up); end
      hold(1'b1, 1'b0, 1'b0, 5);
      checks++; if (bus_w.state !== RUN) begin errors++; $display("FAIL dir_resume_state: got %0d expected 1", bus_w.state); end
      checks++; if (bus_w.cnt_clr !== 1'b0) begin errors++; $display("FAIL dir_resume_clr: got %b expected 0", bus_w.cnt_clr); end
      btn_start = 1'b0;
      repeat (9) step();
      exp_val = prev - 4'd2;
      checks++; if (cnt_model !== exp_val) begin errors++; $display("FAIL dir_count_down: got %0d expected %0d", cnt_model, exp_val); end
      $display("test_dir done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_halt();
      do_reset();
      btn_start = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         step();
         if (c == 5) begin
            btn_start = 1'b0;
            cnt_val_h = 4'd15;
            checks++; if (bus_h.state !== RUN || bus_h.cnt_clr !== 1'b1) begin errors++; $display("FAIL halt_entry: got state=%0d clr=%b expected 1/1", bus_h.state, bus_h.cnt_clr); end
         end
         if (c >= 6) begin
            checks++; if (bus_h.cnt_en !== 1'b0) begin errors++; $display("FAIL halt_no_en c=%0d: got %b expected 0", c, bus_h.cnt_en); end
            checks++; if (bus_h.state !== ((c >= 9) ? HALT : RUN)) begin errors++; $display("FAIL halt_state c=%0d: got %0d expected %0d", c, bus_h.state, (c >= 9) ? 3 : 1); end
         end
         if (c == 9) begin
            checks++; if (bus_w.cnt_en !== 1'b1) begin errors++; $display("FAIL wrap_dut_en: got %b expected 1", bus_w.cnt_en); end
         end
      end
      hold(1'b1, 1'b0, 1'b0, 5);
      checks++; if (bus_h.state !== RUN) begin errors++; $display("FAIL halt_restart_state: got %0d expected 1", bus_h.state); end
      checks++; if (bus_h.cnt_clr !== 1'b1) begin errors++; $display("FAIL halt_restart_clr: got %b expected 1", bus_h.cnt_clr); end
      release_all();
      $display("test_halt done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      hold(1'b0, 1'b0, 1'b1, 5);
      release_all();
      checks++; if (bus_w.cnt_up !== 1'b0) begin errors++; $display("FAIL mid_idle_toggle: got %b expected 0", bus_w.cnt_up); end
      hold(1'b1, 1'b0, 1'b0, 5);
      btn_start = 1'b0;
      checks++; if (bus_w.state !== RUN) begin errors++; $display("FAIL mid_run_state: got %0d expected 1", bus_w.state); end
      repeat (2) step();
      rst = 1'b1;
      step();
      checks++; if (bus_w.state !== IDLE) begin errors++; $display("FAIL mid_rst_state: got %0d expected 0", bus_w.state); end
      checks++; if (bus_w.cnt_up !== 1'b1) begin errors++; $display("FAIL mid_rst_up: got %b expected 1", bus_w.cnt_up); end
      checks++; if (bus_w.cnt_en !== 1'b0 || bus_w.cnt_clr !== 1'b0) begin errors++; $display("FAIL mid_rst_strobe: got en=%b clr=%b expected 0/0", bus_w.cnt_en, bus_w.cnt_clr); end
      rst = 1'b0;
      step();
      checks++; if (bus_w.cnt_en !== 1'b0 || bus_w.cnt_clr !== 1'b0) begin errors++; $display("FAIL mid_post_strobe: got en=%b clr=%b expected 0/0", bus_w.cnt_en, bus_w.cnt_clr); end
      btn_start = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         step();
         if (c == 5) btn_start = 1'b0;
         checks++; if (bus_w.cnt_en !== (c == 9)) begin errors++; $display("FAIL mid_restart_en c=%0d: got %b expected %b", c, bus_w.cnt_en, (c == 9)); end
         checks++; if (bus_w.cnt_clr !== (c == 5)) begin errors++; $display("FAIL mid_restart_clr c=%0d: got %b expected %b", c, bus_w.cnt_clr, (c == 5)); end
      end
      $display("test_reset_mid_run done: checks=%0d errors=%0d", checks, errors);
   endtask

   initial begin
      test_reset();
      test_short_press();
      test_start();
      test_start_stop_together();
      test_dir();
      test_halt();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Run-control sequencer for the 4-bit LED counter. Takes three synchronized push-button levels (start, stop, direction), debounces them, and drives the counter's enable, direction and clear strobes from a prescaled tick through a four-state FSM. Sits between the board button inputs and the counter datapath, in the synchronous reset domain produced by the reset bridge.

## Interface
- `TICK_DIV`, 50_000_000: clock cycles per count step; minimum 2.
- `DEBOUNCE_CYC`, 1_000_000: consecutive stable cycles before a button level is accepted; minimum 1.
- `WRAP`, 1: 1 = free-run with wrap-around; 0 = halt at the terminal value.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `btn_start`  in  1  start/resume button, already synchronized to `clk`.
- `btn_stop`  in  1  pause/stop button, already synchronized.
- `btn_dir`  in  1  direction-toggle button, already synchronized.
- `cnt_val`  in  4  current counter value, fed back from the counter.
- `cnt_en`  out  1  one-cycle count strobe.
- `cnt_up`  out  1  count direction: 1 = up, 0 = down.
- `cnt_clr`  out  1  one-cycle clear strobe to the counter.
- `state`  out  2  current FSM state (`state_e` encoding).

## Operation
- Debounce, per button: the accepted level follows the raw input once the raw input has differed from the accepted level for `DEBOUNCE_CYC` consecutive cycles. A rising edge of the accepted level produces a one-cycle event: `start_ev`, `stop_ev` or `dir_ev`. Falling edges produce no event.
- FSM states: `IDLE`=0, `RUN`=1, `PAUSE`=2, `HALT`=3.
- In `IDLE`:
  - `start_ev` → `RUN`, with a `cnt_clr` pulse.
- In `RUN`:
  - `stop_ev` → `PAUSE`.
  - Each prescaler tick pulses `cnt_en`.
  - If `WRAP`=0 and a tick occurs while `cnt_val` is at the terminal value (15 when up, 0 when down), `cnt_en` is suppressed and the FSM goes to `HALT`.
- In `PAUSE`:
  - `start_ev` → `RUN`, no clear.
  - `stop_ev` → `IDLE`, with a `cnt_clr` pulse.
- In `HALT`:
  - `start_ev` → `RUN`, with a `cnt_clr` pulse.
  - `stop_ev` → `IDLE`, with a `cnt_clr` pulse.
- `dir_ev` toggles `cnt_up` in `IDLE`, `PAUSE` and `HALT`. It is ignored in `RUN`.
- Simultaneous events: `stop_ev` wins over `start_ev`. `dir_ev` is processed independently in the same cycle.
- With `WRAP`=1 the counter wraps naturally (15→0 up, 0→15 down). The controller takes no action at the boundary.
- Prescaler: `$clog2(TICK_DIV)` bits, counts 0..`TICK_DIV`-1 only in `RUN`, and wraps to 0. The tick is asserted when the prescaler equals `TICK_DIV`-1. The prescaler is forced to 0 on every entry to `RUN` and holds at 0 outside `RUN`.

## Timing
- All outputs are registered.
- Reset values: `state`=`IDLE`, `cnt_en`=0, `cnt_clr`=0, `cnt_up`=1, prescaler=0, accepted button levels=0, events=0.
- Reset mid-operation: reset returns to the reset values on the next edge. No `cnt_clr` is emitted, because the counter has its own reset.
- Event latency: if a raw input rises at cycle t and stays high, the event is high in cycle t+`DEBOUNCE_CYC`+1.
- FSM latency: `state` and `cnt_clr` update on the edge after the event cycle.
- First `cnt_en` arrives `TICK_DIV` cycles after `state` becomes `RUN`. Subsequent strobes are exactly `TICK_DIV` cycles apart.
- `cnt_en` and `cnt_clr` are never high in the same cycle.
- `cnt_val` is sampled on the tick cycle. The counter updates one cycle after `cnt_en`.

## Structure
- Package `counter_pkg`: `state_e` enum (2-bit, encoding as above) and `CNT_W`=4.
- Sub-module `btn_debounce` (params `DEBOUNCE_CYC`; ports `clk`, `rst`, `din`, `level`, `rise`), instantiated three times.
- FSM, prescaler and direction register live in `counter_ctrl`.

## Test plan
All scenarios use `TICK_DIV`=4 and `DEBOUNCE_CYC`=3.
- Hold `btn_start` high for 5 cycles from `IDLE` → `cnt_clr` pulses once, `state`=1, then `cnt_en` pulses every 4 cycles starting 4 cycles after entry.
- Hold `btn_start` high for only 2 cycles, then release → no event, `state` stays 0, no strobes.
- In `RUN`, assert `btn_start` and `btn_stop` together for 5 cycles → `state`=2 (`PAUSE`), no `cnt_clr`, `cnt_en` stays low.
- In `RUN`, press `btn_dir` → `cnt_up` unchanged. In `PAUSE`, press `btn_dir` → `cnt_up` toggles 1→0, and after resume the counter counts down.
- With `WRAP`=0, counting up with `cnt_val` driven to 15 at a tick → no `cnt_en` that cycle, `state`=3. Then press start → `cnt_clr` pulses and `state`=1.
- Assert `rst` mid-`RUN` with the prescaler at 2 → the next cycle shows `state`=0, `cnt_up`=1, no strobes. The next start yields its first `cnt_en` a full 4 cycles after entry.
